// File: rtl/mips_cycle_sequencer.sv
// Multi-cycle instruction sequencer for the 16-bit MIPS core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// datapath strobes. The memory-wait watchdog is compiled in by defining
// MIPS_SEQ_WATCHDOG_EN; without it bus_error is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// FETCH  | instruction read outstanding, wait for mem_ready
// DECODE | classify ir_opcode/ir_funct; J and SYSCALL finish here
// EXEC   | branch resolution, or hand-off to MEM/WB
// MEM    | LW read or SW write outstanding, wait for mem_ready
// WB     | register-file write
// HALT   | machine stopped until resume (SYSCALL or bus timeout)
module mips_cycle_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  ir_opcode,
    input  logic [5:0]  ir_funct,
    input  logic        branch_taken,
    input  logic        mem_ready,
    input  logic        resume,
    output logic        ir_load,
    output logic        pc_load,
    output logic [1:0]  pc_src,
    output logic        mem_read,
    output logic        mem_write,
    output logic        rw_ctrl,
    output logic        halted,
    output logic        illegal,
    output logic        bus_error,
    output logic [15:0] retire_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU    = 2'd0,
        CLS_BRANCH = 2'd1,
        CLS_LW     = 2'd2,
        CLS_SW     = 2'd3
    } cls_t;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 255)) begin : g_timeout_range_bad
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_t state, state_nxt;
    cls_t   cls, dec_cls;
    logic   dec_legal, dec_jump, dec_syscall;
    logic   retire, set_illegal, timeout;

    // Instruction classification from the IR fields (meaningful in DECODE only).
    always_comb begin
        dec_cls     = CLS_ALU;
        dec_legal   = 1'b0;
        dec_jump    = 1'b0;
        dec_syscall = 1'b0;
        case (ir_opcode)
            6'b000000: begin
                case (ir_funct)
                    6'b001100: begin
                        dec_legal   = 1'b1;
                        dec_syscall = 1'b1;
                    end
                    6'b100000, 6'b100010, 6'b100001, 6'b100011, 6'b100100,
                    6'b100101, 6'b000000, 6'b000010, 6'b101010, 6'b101011:
                        dec_legal = 1'b1;
                    default: dec_legal = 1'b0;
                endcase
            end
            6'b000010: begin
                dec_legal = 1'b1;
                dec_jump  = 1'b1;
            end
            // 000011 is BLTZ on this core, not JAL.
            6'b000100, 6'b000101, 6'b000111, 6'b000001, 6'b000011: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_BRANCH;
            end
            6'b100011: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_LW;
            end
            6'b101011: begin
                dec_legal = 1'b1;
                dec_cls   = CLS_SW;
            end
            6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001111,
            6'b001010, 6'b001011:
                dec_legal = 1'b1;
            default: dec_legal = 1'b0;
        endcase
    end

    // Next state and strobes; strobes are forced low while reset is held.
    always_comb begin
        state_nxt   = state;
        ir_load     = 1'b0;
        pc_load     = 1'b0;
        pc_src      = PC_SEQ;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        rw_ctrl     = 1'b0;
        halted      = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    if (timeout) begin
                        state_nxt = S_HALT;
                    end else begin
                        mem_read = 1'b1;
                        if (mem_ready) begin
                            ir_load   = 1'b1;
                            pc_load   = 1'b1;
                            pc_src    = PC_SEQ;
                            state_nxt = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (!dec_legal) begin
                        set_illegal = 1'b1;
                        state_nxt   = S_FETCH;
                    end else if (dec_syscall) begin
                        retire    = 1'b1;
                        state_nxt = S_HALT;
                    end else if (dec_jump) begin
                        pc_load   = 1'b1;
                        pc_src    = PC_JUMP;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        CLS_BRANCH: begin
                            if (branch_taken) begin
                                pc_load = 1'b1;
                                pc_src  = PC_BRANCH;
                            end
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                        CLS_LW, CLS_SW: state_nxt = S_MEM;
                        default:        state_nxt = S_WB;
                    endcase
                end
                S_MEM: begin
                    if (timeout) begin
                        state_nxt = S_HALT;
                    end else if (cls == CLS_LW) begin
                        mem_read = 1'b1;
                        if (mem_ready) state_nxt = S_WB;
                    end else begin
                        mem_write = 1'b1;
                        if (mem_ready) begin
                            retire    = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                end
                S_WB: begin
                    rw_ctrl   = 1'b1;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (resume) state_nxt = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    // State, latched class, sticky illegal flag and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            cls          <= CLS_ALU;
            illegal      <= 1'b0;
            retire_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE) cls <= dec_cls;
            if (set_illegal) illegal <= 1'b1;
            if (retire) retire_count <= retire_count + 16'd1;
        end
    end

`ifdef MIPS_SEQ_WATCHDOG_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] wd_cnt;

    // The cycle whose low mem_ready brings the count to TIMEOUT_CYCLES aborts.
    assign timeout = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready
                     && (wd_cnt == WD_LAST);

    // Wait counter restarts on every state change, so entering FETCH/MEM starts at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt    <= 8'd0;
            bus_error <= 1'b0;
        end else begin
            if (state_nxt != state) begin
                wd_cnt <= 8'd0;
            end else if (((state == S_FETCH) || (state == S_MEM)) && !mem_ready) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            if (timeout) bus_error <= 1'b1;
        end
    end
`else
    assign timeout   = 1'b0;
    assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Self-checking bench for mips_cycle_sequencer: random instruction stream with
// random memory waits, expected per-cycle strobes expanded from each
// instruction's class, plus directed reset, halt/resume and timeout steps.
module tb_mips_cycle_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ir_opcode, ir_funct;
    logic        branch_taken, mem_ready, resume;
    logic        ir_load, pc_load, mem_read, mem_write, rw_ctrl, halted;
    logic        illegal, bus_error;
    logic [1:0]  pc_src;
    logic [15:0] retire_count;

    int checks   = 0;
    int failures = 0;
    int exp_retire = 0;
    logic exp_illegal = 1'b0;

    localparam int K_ALU = 0, K_BR = 1, K_LW = 2, K_SW = 3, K_J = 4, K_SYS = 5, K_ILL = 6;

    // Packed strobe vector: {ir_load, pc_load, pc_src[1:0], mem_read, mem_write, rw_ctrl, halted}
    localparam logic [7:0] V_ZERO = 8'h00, V_FWAIT = 8'h08, V_FDONE = 8'hC8,
                           V_JUMP = 8'h60, V_BTAKE = 8'h50, V_RD = 8'h08,
                           V_WR = 8'h04, V_WB = 8'h02, V_HALT = 8'h01;

    logic [5:0] alu_fn [10] = '{6'b100000, 6'b100010, 6'b100001, 6'b100011, 6'b100100,
                                6'b100101, 6'b000000, 6'b000010, 6'b101010, 6'b101011};
    logic [5:0] imm_op [7]  = '{6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001111,
                                6'b001010, 6'b001011};
    logic [5:0] br_op  [5]  = '{6'b000100, 6'b000101, 6'b000111, 6'b000001, 6'b000011};
    logic [5:0] bad_fn [3]  = '{6'b000001, 6'b111111, 6'b011000};

    mips_cycle_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ir_opcode(ir_opcode), .ir_funct(ir_funct),
        .branch_taken(branch_taken), .mem_ready(mem_ready), .resume(resume),
        .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src), .mem_read(mem_read),
        .mem_write(mem_write), .rw_ctrl(rw_ctrl), .halted(halted), .illegal(illegal),
        .bus_error(bus_error), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] outv();
        return {ir_load, pc_load, pc_src, mem_read, mem_write, rw_ctrl, halted};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000) begin
            if (fn == 6'b001100) return K_SYS;
            foreach (alu_fn[i]) if (alu_fn[i] == fn) return K_ALU;
            return K_ILL;
        end
        if (op == 6'b000010) return K_J;
        if (op == 6'b100011) return K_LW;
        if (op == 6'b101011) return K_SW;
        foreach (br_op[i])  if (br_op[i] == op)  return K_BR;
        foreach (imm_op[i]) if (imm_op[i] == op) return K_ALU;
        return K_ILL;
    endfunction

    // Expand one instruction into its expected cycle trace and drive/check it.
    // rdy entries: 0/1 drive mem_ready, 2 = don't-care (random noise).
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic taken, input int wf, input int wm);
        logic [7:0] exp_q[$];
        int         rdy_q[$];
        int         kind, exec_idx;
        kind = classify(op, fn);
        for (int i = 0; i < wf; i++) begin exp_q.push_back(V_FWAIT); rdy_q.push_back(0); end
        exp_q.push_back(V_FDONE); rdy_q.push_back(1);
        exp_q.push_back(kind == K_J ? V_JUMP : V_ZERO); rdy_q.push_back(2);
        exec_idx = exp_q.size();
        if (kind == K_ALU || kind == K_BR || kind == K_LW || kind == K_SW) begin
            exp_q.push_back((kind == K_BR && taken) ? V_BTAKE : V_ZERO); rdy_q.push_back(2);
        end
        if (kind == K_LW || kind == K_SW) begin
            for (int i = 0; i < wm; i++) begin
                exp_q.push_back(kind == K_LW ? V_RD : V_WR); rdy_q.push_back(0);
            end
            exp_q.push_back(kind == K_LW ? V_RD : V_WR); rdy_q.push_back(1);
        end
        if (kind == K_ALU || kind == K_LW) begin
            exp_q.push_back(V_WB); rdy_q.push_back(2);
        end
        if (kind != K_ILL) exp_retire++;
        else exp_illegal = 1'b1;

        ir_opcode = op;
        ir_funct  = fn;
        for (int i = 0; i < exp_q.size(); i++) begin
            mem_ready    = (rdy_q[i] == 2) ? 1'($urandom) : rdy_q[i][0];
            branch_taken = (i == exec_idx) ? taken : 1'($urandom);
            resume       = 1'($urandom);
            @(negedge clk);
            chk($sformatf("trace op=%0h fn=%0h cyc=%0d", op, fn, i), 32'(outv()), 32'(exp_q[i]));
            @(posedge clk); #1;
        end
        chk($sformatf("retire op=%0h", op), 32'(retire_count), 32'(16'(exp_retire)));
        chk($sformatf("illegal op=%0h", op), 32'(illegal), 32'(exp_illegal));
    endtask

    task automatic halt_phase();
        for (int i = 0; i < 10; i++) begin
            resume       = 1'b0;
            mem_ready    = 1'($urandom);
            branch_taken = 1'($urandom);
            @(negedge clk);
            chk($sformatf("halt idle %0d", i), 32'(outv()), 32'(V_HALT));
            @(posedge clk); #1;
        end
        resume = 1'b1;
        @(negedge clk);
        chk("halt resume cycle", 32'(outv()), 32'(V_HALT));
        @(posedge clk); #1;
        resume = 1'b0;
    endtask

    task automatic random_instr();
        logic [5:0] op, fn;
        int kind;
        kind = $urandom_range(0, 6);
        fn   = 6'($urandom);
        case (kind)
            0:       begin op = 6'b000000; fn = alu_fn[$urandom_range(0, 9)]; end
            1:       op = imm_op[$urandom_range(0, 6)];
            2:       op = br_op[$urandom_range(0, 4)];
            3:       op = ($urandom_range(0, 1) == 0) ? 6'b100011 : 6'b101011;
            4:       op = 6'b000010;
            5:       begin op = 6'b000000; fn = 6'b001100; end
            default: begin op = 6'b000000; fn = bad_fn[$urandom_range(0, 2)]; end
        endcase
        run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        if (classify(op, fn) == K_SYS) halt_phase();
    endtask

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; resume = 1'b0; branch_taken = 1'b0;
        ir_opcode = 6'd0; ir_funct = 6'd0;
        @(negedge clk);
        chk("reset strobes", 32'(outv()), 32'(V_ZERO));
        chk("reset retire", 32'(retire_count), 32'd0);
        chk("reset flags", 32'({illegal, bus_error}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);      // ADD
        run_instr(6'b100011, 6'b000000, 1'b0, 0, 3);      // LW, 3 waits in MEM
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);      // BEQ taken
        run_instr(6'b000101, 6'b000000, 1'b0, 0, 0);      // BNE not taken
        run_instr(6'b101011, 6'b000000, 1'b0, 2, 1);      // SW with waits
        run_instr(6'b000010, 6'b000000, 1'b0, 1, 0);      // J
        run_instr(6'b000000, 6'b001100, 1'b0, 0, 0);      // SYSCALL
        halt_phase();
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);      // illegal opcode
        for (int n = 0; n < 40; n++) random_instr();

        // Reset asserted mid-MEM of an LW must clear everything without a clock edge.
        ir_opcode = 6'b100011; mem_ready = 1'b1;
        @(posedge clk); #1 mem_ready = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("mid-mem read", 32'(mem_read), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset strobes", 32'(outv()), 32'(V_ZERO));
        chk("async reset retire", 32'(retire_count), 32'd0);
        chk("async reset flags", 32'({illegal, bus_error}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("fetch after reset", 32'(outv()), 32'(V_FWAIT));

`ifdef MIPS_SEQ_WATCHDOG_EN
        // Already one low cycle in FETCH; three more reach the limit of 4.
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("watchdog drop", 32'(mem_read), 32'd0);
        @(posedge clk); #1;
        chk("watchdog halted", 32'(halted), 32'd1);
        chk("watchdog bus_error", 32'(bus_error), 32'd1);
        chk("watchdog no retire", 32'(retire_count), 32'd0);
`else
        for (int i = 0; i < 6; i++) begin @(posedge clk); #1; end
        chk("no watchdog still fetching", 32'(outv()), 32'(V_FWAIT));
        chk("no watchdog bus_error", 32'(bus_error), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout sim did not finish");
        $fatal(1, "time limit");
    end

endmodule
